// File: rtl/matrix_uop_sequencer.sv
// Expands decoded matrix instructions (MLOAD A/B, MMUL) into scalar micro-ops; others pass through.
// Optional perf counters are built when MATRIX_UOP_SEQ_PERF_EN is defined.
`default_nettype none

module matrix_uop_sequencer #(
  parameter int NRW  = 5,
  parameter int CNTW = 4,
  parameter int TAGW = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_instr_id,
  input  logic [1:0]      in_m_type,
  input  logic [CNTW-1:0] in_row_size,
  input  logic [NRW-1:0]  in_rd,
  input  logic [NRW-1:0]  in_rs1,
  input  logic [NRW-1:0]  in_rs2,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NRW-1:0]  out_rd,
  output logic [NRW-1:0]  out_rs1,
  output logic [NRW-1:0]  out_rs2,
  output logic [CNTW-1:0] out_idx,
  output logic            out_last,
  output logic            out_acc,
  output logic [TAGW-1:0] out_tag,
  output logic            busy,
  output logic [31:0]     perf_uops,
  output logic [31:0]     perf_stalls
);

  localparam logic [2:0]      ID_MLOAD = 3'd1;
  localparam logic [2:0]      ID_MMUL  = 3'd3;
  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};

  typedef enum logic [1:0] {IDLE = 2'd0, SINGLE = 2'd1, EXPAND = 2'd2} state_t;
  typedef enum logic [1:0] {K_PASS = 2'd0, K_LOAD = 2'd1, K_MUL = 2'd2} kind_t;

  state_t          state, state_next;
  kind_t           cap_kind, in_kind;
  logic [NRW-1:0]  cap_rd, cap_rs1, cap_rs2;
  logic [CNTW-1:0] cap_row, cap_last_idx, in_last_idx, idx;
  logic [TAGW-1:0] cap_tag;
  logic            accept, handshake;

  // Decode kind and last micro-op index (N-1) of the incoming instruction.
  always_comb begin
    in_kind     = K_PASS;
    in_last_idx = '0;
    if (in_instr_id == ID_MLOAD && in_m_type < 2'd2) begin
      in_kind     = K_LOAD;
      in_last_idx = (in_row_size == '0) ? '0 : in_row_size - 1'b1;
    end else if (in_instr_id == ID_MMUL) begin
      in_kind     = K_MUL;
      in_last_idx = (in_row_size == CNT_MAX) ? CNT_MAX - 1'b1 : in_row_size;
    end
  end

  assign handshake = out_valid && out_ready;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    out_valid  = (state != IDLE);
    busy       = (state == EXPAND);
    out_last   = out_valid && (idx == cap_last_idx);
    in_ready   = !out_valid || (out_last && out_ready);
    if (accept)
      state_next = (in_last_idx == '0) ? SINGLE : EXPAND;
    else if (handshake && out_last)
      state_next = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_kind     <= K_PASS;
      cap_rd       <= '0;
      cap_rs1      <= '0;
      cap_rs2      <= '0;
      cap_row      <= '0;
      cap_last_idx <= '0;
      cap_tag      <= '0;
      idx          <= '0;
    end else if (accept) begin
      cap_kind     <= in_kind;
      cap_rd       <= in_rd;
      cap_rs1      <= in_rs1;
      cap_rs2      <= in_rs2;
      cap_row      <= in_row_size;
      cap_last_idx <= in_last_idx;
      cap_tag      <= in_tag;
      idx          <= '0;
    end else if (handshake && !out_last) begin
      idx <= idx + 1'b1;
    end
  end

  // Micro-op fields derived from captured instruction and current index.
  always_comb begin
    out_rd  = cap_rd;
    out_rs1 = cap_rs1;
    out_rs2 = cap_rs2;
    out_acc = 1'b0;
    out_idx = idx;
    out_tag = cap_tag;
    case (cap_kind)
      K_LOAD: out_rd = cap_rd + NRW'(idx);
      K_MUL: begin
        out_acc = out_valid && (idx < cap_row);
        if (idx == '0) begin
          out_rd = cap_rs1;
        end else if (idx == CNTW'(1)) begin
          out_rd  = cap_rs2;
          out_rs1 = cap_rs1 + NRW'(1);
          out_rs2 = cap_rs2 + NRW'(1);
        end
      end
      default: ;
    endcase
  end

`ifdef MATRIX_UOP_SEQ_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_uops   <= '0;
      perf_stalls <= '0;
    end else begin
      if (handshake)              perf_uops   <= perf_uops + 32'd1;
      if (out_valid && !out_ready) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`else
  assign perf_uops   = '0;
  assign perf_stalls = '0;
`endif

endmodule

`default_nettype wire
